// File: rtl/segment_store_ctrl.sv
// Segment store controller: saves the four-word L1 window to backing store or restores it,
// addressed by the {SA,SB,SC} triple latched when the request is accepted.
module segment_store_ctrl #(
    parameter int DATA_W = 16,
    parameter int SEG_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 store_write,
    input  logic                 store_read,
    input  logic                 store_call,
    output logic                 store_busy,
    input  logic [SEG_W-1:0]     SA,
    input  logic [SEG_W-1:0]     SB,
    input  logic [SEG_W-1:0]     SC,
    output logic                 L1_write,
    output logic                 L1_read,
    output logic [1:0]           L1_ADDR,
    inout  wire  [DATA_W-1:0]    L12loader,
    output logic [3*SEG_W+1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]    MEM_WDATA,
    input  logic [DATA_W-1:0]    MEM_RDATA,
    output logic                 MEM_WE,
    output logic                 MEM_RE,
    input  logic                 MEM_ACK,
    output logic [2:0]           o_dbg_state
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_L1  = 3'd1;
    localparam logic [2:0] MEM_WR = 3'd2;
    localparam logic [2:0] MEM_RD = 3'd3;
    localparam logic [2:0] WR_L1  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic [2:0]        r_state;
    logic [1:0]        r_idx;
    logic [SEG_W-1:0]  r_sa;
    logic [SEG_W-1:0]  r_sb;
    logic [SEG_W-1:0]  r_sc;
    logic [DATA_W-1:0] r_data;

    logic w_save_req;
    logic w_load_req;
    logic w_last;

    assign w_save_req = store_write | store_call;
    assign w_load_req = store_read;
    assign w_last     = (r_idx == 2'd3);

    // Memory handshake: MEM_WE/MEM_RE stay high with MEM_ADDR (and MEM_WDATA) stable
    // until a cycle with MEM_ACK=1; the word transfers on that rising edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_idx   <= 2'd0;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sc    <= '0;
            r_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_save_req) begin
                        r_sa    <= SA;
                        r_sb    <= SB;
                        r_sc    <= SC;
                        r_idx   <= 2'd0;
                        r_state <= RD_L1;
                    end else if (w_load_req) begin
                        r_sa    <= SA;
                        r_sb    <= SB;
                        r_sc    <= SC;
                        r_idx   <= 2'd0;
                        r_state <= MEM_RD;
                    end
                end
                RD_L1: begin
                    r_data  <= L12loader;
                    r_state <= MEM_WR;
                end
                MEM_WR: begin
                    if (MEM_ACK) begin
                        if (w_last) begin
                            r_idx   <= 2'd0;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= RD_L1;
                        end
                    end
                end
                MEM_RD: begin
                    if (MEM_ACK) begin
                        r_data  <= MEM_RDATA;
                        r_state <= WR_L1;
                    end
                end
                WR_L1: begin
                    if (w_last) begin
                        r_idx   <= 2'd0;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= MEM_RD;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Busy rises combinationally in the request cycle so the IP never advances past it.
    assign store_busy = ((r_state != IDLE) && (r_state != DONE)) ||
                        ((r_state == IDLE) && (w_save_req || w_load_req));

    assign L1_write    = (r_state == RD_L1);
    assign L1_read     = (r_state == WR_L1);
    assign L1_ADDR     = r_idx;
    assign MEM_WE      = (r_state == MEM_WR);
    assign MEM_RE      = (r_state == MEM_RD);
    assign MEM_ADDR    = {r_sa, r_sb, r_sc, r_idx};
    assign MEM_WDATA   = r_data;
    assign o_dbg_state = r_state;

    assign L12loader = (r_state == WR_L1) ? r_data : {DATA_W{1'bz}};

endmodule
